inst_fetch_unit: RTL and testbench

- Instruction source sitting directly upstream of the CPU core.
- Holds a loadable program memory and answers the core's fetch request handshake (id, pc).
- Returns decoded instructions on the core's inst_* handshake, buffered in a small response FIFO, and flags the final program instruction with inst_last.

---
 rtl/cpu_fetch_pkg.sv | 53 +++++
 rtl/inst_fetch_unit_fifo.sv | 75 +++++++
 rtl/inst_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared widths, decode offsets, FSM states and response entry for the fetch unit.
// Imported by inst_fetch_unit and its response queue.
package cpu_fetch_pkg;

  localparam int NUM_FU      = 8;
  localparam int NUM_REG     = 8;
  localparam int IMM_BIT     = 4;
  localparam int INST_ID_BIT = 8;

  localparam int OP_BIT   = $clog2(NUM_FU);
  localparam int REG_BIT  = $clog2(NUM_REG);
  localparam int INST_BIT = OP_BIT + 3*REG_BIT + IMM_BIT;

  // word packing, MSB to LSB: {op, dst, src0, src1, imm}
  localparam int IMM_LSB  = 0;
  localparam int SRC1_LSB = IMM_LSB + IMM_BIT;
  localparam int SRC0_LSB = SRC1_LSB + REG_BIT;
  localparam int DST_LSB  = SRC0_LSB + REG_BIT;
  localparam int OP_LSB   = DST_LSB + REG_BIT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ID_BIT-1:0] id;
    logic                   last;
    logic [OP_BIT-1:0]      op;
    logic [REG_BIT-1:0]     dst;
    logic [REG_BIT-1:0]     src0;
    logic [REG_BIT-1:0]     src1;
    logic [IMM_BIT-1:0]     imm;
  } resp_t;

  function automatic resp_t decode(
    input logic [INST_BIT-1:0]    w,
    input logic [INST_ID_BIT-1:0] id,
    input logic                   last
  );
    resp_t r;
    r.id   = id;
    r.last = last;
    r.op   = w[OP_LSB   +: OP_BIT];
    r.dst  = w[DST_LSB  +: REG_BIT];
    r.src0 = w[SRC0_LSB +: REG_BIT];
    r.src1 = w[SRC1_LSB +: REG_BIT];
    r.imm  = w[IMM_LSB  +: IMM_BIT];
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// sync_fifo: synchronous FIFO, any DEPTH >= 2, pointers wrap modulo DEPTH.
// Ports: flush_i/push_i/din_i/pop_i in; dout_o (head), count_o, full_o, empty_o out.
module sync_fifo #(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 4,
  localparam int PTR_BIT = $clog2(DEPTH),
  localparam int CNT_BIT = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   din_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   dout_o,
  output logic [CNT_BIT-1:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_BIT-1:0] wr_q, wr_d;
  logic [PTR_BIT-1:0] rd_q, rd_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_BIT-1:0] inc(
    input logic [PTR_BIT-1:0] p
  );
    return (p == PTR_BIT'(DEPTH - 1)) ? '0 : p + PTR_BIT'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_BIT'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // a pop frees the slot the push needs, even when full
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = inc(wr_q);
      if (do_pop)  rd_d = inc(rd_q);
      if (do_push && !do_pop) cnt_d = cnt_q + CNT_BIT'(1);
      if (do_pop && !do_push) cnt_d = cnt_q - CNT_BIT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Program memory + fetch handshake; decoded responses queued into sync_fifo.
// Ports: load_* (program write), start/prog_len, fetch_* (request), inst_* (response),
// done, id_err. Optional id sequence check built when FETCH_ID_CHECK_EN is defined.
module inst_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter  int PROG_DEPTH = 256,
  parameter  int FIFO_DEPTH = 4,
  localparam int PC_BIT     = $clog2(PROG_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_vld,
  output logic                   load_rdy,
  input  logic [PC_BIT-1:0]      load_addr,
  input  logic [INST_BIT-1:0]    load_data,
  input  logic [PC_BIT:0]        prog_len,
  input  logic                   start,
  input  logic                   fetch_vld,
  output logic                   fetch_rdy,
  input  logic [INST_ID_BIT-1:0] fetch_id,
  input  logic [PC_BIT-1:0]      fetch_pc,
  output logic                   inst_vld,
  input  logic                   inst_rdy,
  output logic                   inst_last,
  output logic [OP_BIT-1:0]      inst_op,
  output logic [INST_ID_BIT-1:0] inst_id,
  output logic [REG_BIT-1:0]     inst_dst_reg,
  output logic [REG_BIT-1:0]     inst_src_reg0,
  output logic [REG_BIT-1:0]     inst_src_reg1,
  output logic [IMM_BIT-1:0]     inst_imm,
  output logic                   done,
  output logic                   id_err
);

  localparam int CNT_BIT  = $clog2(FIFO_DEPTH + 1);
  localparam int RESP_BIT = $bits(resp_t);

  fetch_state_e state_q, state_d;

  logic [PC_BIT:0]       len_q;
  logic [INST_BIT-1:0]   prog_q [PROG_DEPTH];
  logic                  stg_vld_q, stg_vld_d;
  resp_t                 stg_q, stg_d;
  logic [CNT_BIT-1:0]    fifo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [RESP_BIT-1:0]   head_raw;
  resp_t                 head;
  resp_t                 out;
  logic                  fetch_fire;
  logic                  pop;
  logic                  flush;
  logic [PC_BIT:0]       pc_ext;
  logic [PC_BIT:0]       last_pc;

  assign load_rdy = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign flush    = (state_q == DONE);

  // stage slot counts against capacity; a same-cycle pop is not credited
  assign fetch_rdy  = (state_q == RUN) && !fifo_full &&
                      (int'(fifo_cnt) + int'(stg_vld_q) < FIFO_DEPTH);
  assign fetch_fire = fetch_vld && fetch_rdy;

  assign pc_ext  = {1'b0, fetch_pc};
  assign last_pc = len_q - (PC_BIT+1)'(1);

  assign head     = resp_t'(head_raw);
  assign inst_vld = (state_q == RUN) && !fifo_empty;
  assign pop      = inst_vld && inst_rdy;
  assign out      = inst_vld ? head : '0;

  assign inst_last     = out.last;
  assign inst_op       = out.op;
  assign inst_id       = out.id;
  assign inst_dst_reg  = out.dst;
  assign inst_src_reg0 = out.src0;
  assign inst_src_reg1 = out.src1;
  assign inst_imm      = out.imm;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (prog_len == '0) ? DONE : RUN;
      RUN:  if (pop && head.last) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // out-of-range fetches are accepted but never reach the stage
  always_comb begin
    stg_vld_d = fetch_fire && (pc_ext < len_q);
    stg_d     = stg_q;
    if (fetch_fire)
      stg_d = decode(prog_q[fetch_pc], fetch_id, pc_ext == last_pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
    end else begin
      state_q   <= state_d;
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
      if (state_q == IDLE && start) len_q <= prog_len;
    end
  end

  always_ff @(posedge clk) begin
    if (load_vld && load_rdy) prog_q[load_addr] <= load_data;
  end

  sync_fifo #(
    .WIDTH (RESP_BIT),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (stg_vld_q),
    .din_i   (stg_q),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef FETCH_ID_CHECK_EN
  logic [INST_ID_BIT-1:0] exp_id_q;
  logic                   id_err_q;

  // resync to the observed id so one slip flags once, not forever
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_id_q <= '0;
      id_err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      exp_id_q <= '0;
    end else if (fetch_fire) begin
      exp_id_q <= fetch_id + INST_ID_BIT'(1);
      if (fetch_id != exp_id_q) id_err_q <= 1'b1;
    end
  end

  assign id_err = id_err_q;
`else
  assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit.
// Drives and samples on the falling edge; expected values are hand-derived.
module tb_inst_fetch_unit;

`ifdef FETCH_ID_CHECK_EN
  localparam logic ID_CHK = 1'b1;
`else
  localparam logic ID_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        load_vld;
  logic        load_rdy;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [8:0]  prog_len;
  logic        start;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic [7:0]  fetch_id;
  logic [7:0]  fetch_pc;
  logic        inst_vld;
  logic        inst_rdy;
  logic        inst_last;
  logic [2:0]  inst_op;
  logic [7:0]  inst_id;
  logic [2:0]  inst_dst_reg;
  logic [2:0]  inst_src_reg0;
  logic [2:0]  inst_src_reg1;
  logic [3:0]  inst_imm;
  logic        done;
  logic        id_err;

  int n_vec;
  int n_err;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_vld      (load_vld),
    .load_rdy      (load_rdy),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .prog_len      (prog_len),
    .start         (start),
    .fetch_vld     (fetch_vld),
    .fetch_rdy     (fetch_rdy),
    .fetch_id      (fetch_id),
    .fetch_pc      (fetch_pc),
    .inst_vld      (inst_vld),
    .inst_rdy      (inst_rdy),
    .inst_last     (inst_last),
    .inst_op       (inst_op),
    .inst_id       (inst_id),
    .inst_dst_reg  (inst_dst_reg),
    .inst_src_reg0 (inst_src_reg0),
    .inst_src_reg1 (inst_src_reg1),
    .inst_imm      (inst_imm),
    .done          (done),
    .id_err        (id_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // word k: op=k, dst=k+1, src0=k+2, src1=k+3, imm=3k+1 (field-wrapped)
  function automatic logic [15:0] word_of(input int k);
    logic [2:0] op, d, s0, s1;
    logic [3:0] im;
    op = 3'(k);
    d  = 3'(k + 1);
    s0 = 3'(k + 2);
    s1 = 3'(k + 3);
    im = 4'(3*k + 1);
    return {op, d, s0, s1, im};
  endfunction

  task automatic chk_resp(input string tag, input int k,
                          input int id, input logic last);
    chk({tag, "_vld"},  inst_vld, 1);
    chk({tag, "_id"},   inst_id, id);
    chk({tag, "_op"},   inst_op, k % 8);
    chk({tag, "_dst"},  inst_dst_reg, (k + 1) % 8);
    chk({tag, "_s0"},   inst_src_reg0, (k + 2) % 8);
    chk({tag, "_s1"},   inst_src_reg1, (k + 3) % 8);
    chk({tag, "_imm"},  inst_imm, (3*k + 1) % 16);
    chk({tag, "_last"}, inst_last, last);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    load_vld  = 1'b0;
    load_addr = '0;
    load_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    fetch_vld = 1'b0;
    fetch_id  = '0;
    fetch_pc  = '0;
    inst_rdy  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic go(input int n);
    prog_len = 9'(n);
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int acc, got, sent, viol;
    logic have;
    logic [31:0] snap, cur;
    n_vec = 0;
    n_err = 0;

    do_reset();
    chk("rst_load_rdy", load_rdy, 1);
    chk("rst_inst_vld", inst_vld, 0);
    chk("rst_fetch_rdy", fetch_rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_id_err", id_err, 0);
    chk("rst_inst_id", inst_id, 0);

    for (int k = 0; k < 8; k++) begin
      load_vld  = 1'b1;
      load_addr = 8'(k);
      load_data = word_of(k);
      step();
    end
    load_vld = 1'b0;

    // basic: 3 fetches, responses 2 cycles later
    go(3);
    inst_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c <= 4) chk_resp("t1", c - 2, c - 2, c == 4);
      if (c == 4) chk("t1_done_early", done, 0);
      if (c == 5) begin
        chk("t1_done", done, 1);
        chk("t1_vld_after", inst_vld, 0);
      end
      if (c < 3) begin
        chk("t1_frdy", fetch_rdy, 1);
        fetch_vld = 1'b1;
        fetch_id  = 8'(c);
        fetch_pc  = 8'(c);
      end else begin
        fetch_vld = 1'b0;
      end
      step();
    end

    // backpressure
    do_reset();
    go(8);
    chk("t2_load_rdy_run", load_rdy, 0);
    acc = 0;
    viol = 0;
    have = 1'b0;
    snap = '0;
    for (int c = 0; c < 10; c++) begin
      cur = {inst_id, inst_op, inst_dst_reg, inst_src_reg0,
             inst_src_reg1, inst_imm, inst_last};
      if (inst_vld) begin
        if (!have) snap = cur;
        else if (cur !== snap) viol++;
        have = 1'b1;
      end
      fetch_vld = 1'b1;
      fetch_id  = 8'(10 + acc);
      fetch_pc  = 8'(acc);
      if (fetch_rdy) acc++;
      step();
    end
    chk("t2_accepted", acc, 4);
    chk("t2_frdy_full", fetch_rdy, 0);
    chk("t2_seen_vld", have, 1);
    chk("t2_stable", viol, 0);
    fetch_vld = 1'b0;
    inst_rdy  = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (inst_vld) begin
        if (got < 4) chk_resp("t2_drain", got, 10 + got, 1'b0);
        got++;
      end
      step();
    end
    chk("t2_drained", got, 4);

    // prefetch past end
    do_reset();
    go(2);
    inst_rdy = 1'b1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 10; c++) begin
      if (inst_vld) begin
        if (got < 2) chk_resp("t3", got, 20 + got, got == 1);
        got++;
      end
      if (sent < 4) begin
        fetch_vld = 1'b1;
        fetch_id  = 8'(20 + sent);
        fetch_pc  = 8'(sent);
        if (fetch_rdy) sent++;
      end else begin
        fetch_vld = 1'b0;
      end
      step();
    end
    chk("t3_sent", sent, 4);
    chk("t3_resps", got, 2);
    chk("t3_done", done, 1);

    // empty program
    do_reset();
    go(0);
    chk("t4_done", done, 1);
    fetch_vld = 1'b1;
    chk("t4_frdy", fetch_rdy, 0);
    step();
    chk("t4_frdy_hold", fetch_rdy, 0);
    chk("t4_load_rdy", load_rdy, 0);
    fetch_vld = 1'b0;

    // async reset with entries queued
    do_reset();
    go(8);
    for (int c = 0; c < 3; c++) begin
      fetch_vld = 1'b1;
      fetch_id  = 8'(c);
      fetch_pc  = 8'(c);
      step();
    end
    fetch_vld = 1'b0;
    step();
    chk("t5_queued", inst_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_vld", inst_vld, 0);
    chk("t5_load_rdy", load_rdy, 1);
    chk("t5_done", done, 0);
    chk("t5_frdy", fetch_rdy, 0);
    step();
    rst_n = 1'b1;
    step();

    // id sequence 0,1,3
    go(8);
    inst_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) chk("t6_err_pre", id_err, 0);
      if (c == 3) chk("t6_err_set", id_err, ID_CHK);
      if (c == 5) chk("t6_err_hold", id_err, ID_CHK);
      if (c < 3) begin
        fetch_vld = 1'b1;
        fetch_id  = (c == 2) ? 8'd3 : 8'(c);
        fetch_pc  = 8'(c);
      end else begin
        fetch_vld = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
